// File: rtl/systolic_mm_ctrl_pkg.sv
// Shared definitions for the systolic matrix-multiply sequencer and the PE array top:
// FSM state encoding, default array geometry and the width helpers.
package systolic_mm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DONE    = 3'd3,
    ST_HOLD    = 3'd4
  } mm_state_e;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DIM_DEF        = 4;
  localparam int MAX_K_DEF      = 16;

  // clog2 that never returns 0, so a 1-entry range still gets a 1-bit field
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  // width able to hold the value max_k itself
  function automatic int k_width(input int max_k);
    return $clog2(max_k + 1);
  endfunction

  // sequencing counter spans 0 .. max_k+2*dim-1
  function automatic int cnt_width(input int max_k, input int dim);
    return clog2_min1(max_k + 2 * dim);
  endfunction

endpackage

// File: rtl/systolic_mm_ctrl_if.sv
// Operand buffer read bus: one A column and one B row per cycle, 1-cycle read latency.
interface systolic_mm_ctrl_if
  import systolic_mm_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DIM        = DIM_DEF,
  parameter int ADDR_W     = clog2_min1(MAX_K_DEF)
);
  logic                           a_rd_en_o;
  logic [ADDR_W-1:0]              a_addr_o;
  logic [DIM-1:0][DATA_WIDTH-1:0] a_rdata_i;
  logic                           b_rd_en_o;
  logic [ADDR_W-1:0]              b_addr_o;
  logic [DIM-1:0][DATA_WIDTH-1:0] b_rdata_i;

  // sequencer side
  modport master (
    output a_rd_en_o, a_addr_o, b_rd_en_o, b_addr_o,
    input  a_rdata_i, b_rdata_i
  );

  // buffer side
  modport slave (
    input  a_rd_en_o, a_addr_o, b_rd_en_o, b_addr_o,
    output a_rdata_i, b_rdata_i
  );
endinterface

// File: rtl/systolic_mm_ctrl_skew_line.sv
// Diagonal skew: lane i is delayed by exactly i cycles; lane 0 passes straight through.
// Synchronous clear empties every stage so a new job starts from zeros.
module systolic_mm_ctrl_skew_line
  import systolic_mm_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LANES      = DIM_DEF
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clr_i,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] din,
  output logic [LANES-1:0][DATA_WIDTH-1:0] dout
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (i == 0) begin : g_pass
      assign dout[i] = din[i];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] pipe [i];

      // i-deep shift register for this lane
      always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
          for (int n = 0; n < i; n++) pipe[n] <= '0;
        end else begin
          pipe[0] <= din[i];
          for (int n = 1; n < i; n++) pipe[n] <= pipe[n-1];
        end
      end

      assign dout[i] = pipe[i-1];
    end
  end

endmodule

// File: rtl/systolic_mm_ctrl.sv
// Sequencer for a DIM x DIM systolic MAC array: streams K operand columns/rows from
// the buffers, skews them diagonally into the array, drives PE start/mode and
// captures the array overflow summary at completion.
module systolic_mm_ctrl
  import systolic_mm_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DIM        = DIM_DEF,
  parameter int MAX_K      = MAX_K_DEF,
  parameter int K_W        = k_width(MAX_K),
  parameter int ADDR_W     = clog2_min1(MAX_K)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic                           mode_i,
  input  logic [K_W-1:0]                 k_len_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           res_valid_o,
  output logic                           ovf_o,
  systolic_mm_ctrl_if.master             obuf,
  output logic [DIM-1:0][DATA_WIDTH-1:0] a_feed_o,
  output logic [DIM-1:0][DATA_WIDTH-1:0] b_feed_o,
  output logic                           pe_start_o,
  output logic                           pe_mode_o,
  input  logic [DIM*DIM-1:0]             pe_ovf_i
);

  localparam int CNT_W = cnt_width(MAX_K, DIM);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_CLEAR   = ST_CLEAR;
  localparam logic [2:0] S_COMPUTE = ST_COMPUTE;
  localparam logic [2:0] S_DONE    = ST_DONE;
  localparam logic [2:0] S_HOLD    = ST_HOLD;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [K_W-1:0]   k_r;
  logic             mode_r;
  logic             ovf_r;
  logic             rd_vld;
  logic             rd_en;
  logic             in_compute;
  logic [K_W-1:0]   k_sat;
  logic [CNT_W-1:0] cnt_last;

  logic [DIM-1:0][DATA_WIDTH-1:0] a_q, b_q, a_sk, b_sk;

  assign k_sat      = (k_len_i > K_W'(MAX_K)) ? K_W'(MAX_K) : k_len_i;
  // last cycle leaves room for the final term to ripple to PE(DIM-1,DIM-1)
  assign cnt_last   = CNT_W'(k_r) + CNT_W'(2 * DIM - 1);
  assign in_compute = (state == S_COMPUTE);
  assign rd_en      = in_compute && (cnt < CNT_W'(k_r));

  // job FSM; start_i only looked at when idle or holding results
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      cnt    <= '0;
      k_r    <= '0;
      mode_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HOLD: begin
          if (start_i) begin
            state  <= S_CLEAR;
            k_r    <= k_sat;
            mode_r <= mode_i;
          end
        end
        S_CLEAR: begin
          cnt   <= '0;
          state <= (k_r == '0) ? S_DONE : S_COMPUTE;
        end
        S_COMPUTE: begin
          if (cnt == cnt_last) state <= S_DONE;
          else                 cnt   <= cnt + CNT_W'(1);
        end
        S_DONE: begin
          ovf_r <= |pe_ovf_i;
          state <= S_HOLD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // read data arrives one cycle after the strobe; track which cycles carry real data
  always_ff @(posedge clk_i) begin
    if (rst_i) rd_vld <= 1'b0;
    else       rd_vld <= rd_en;
  end

  assign obuf.a_rd_en_o = rd_en;
  assign obuf.b_rd_en_o = rd_en;
  assign obuf.a_addr_o  = rd_en ? ADDR_W'(cnt) : '0;
  assign obuf.b_addr_o  = rd_en ? ADDR_W'(cnt) : '0;

  // stale buffer output must not leak into the array
  assign a_q = rd_vld ? obuf.a_rdata_i : '0;
  assign b_q = rd_vld ? obuf.b_rdata_i : '0;

  systolic_mm_ctrl_skew_line #(.DATA_WIDTH(DATA_WIDTH), .LANES(DIM)) u_skew_a (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state == S_CLEAR),
    .din   (a_q),
    .dout  (a_sk)
  );

  systolic_mm_ctrl_skew_line #(.DATA_WIDTH(DATA_WIDTH), .LANES(DIM)) u_skew_b (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state == S_CLEAR),
    .din   (b_q),
    .dout  (b_sk)
  );

  assign a_feed_o    = in_compute ? a_sk : '0;
  assign b_feed_o    = in_compute ? b_sk : '0;
  assign busy_o      = (state == S_CLEAR) || in_compute || (state == S_DONE);
  assign done_o      = (state == S_DONE);
  assign res_valid_o = (state == S_HOLD);
  // low in IDLE and CLEAR: that is what clears the accumulators
  assign pe_start_o  = in_compute || (state == S_DONE) || (state == S_HOLD);
  assign pe_mode_o   = (state != S_IDLE) && mode_r;
  assign ovf_o       = ovf_r;

endmodule

// File: tb/tb_systolic_mm_ctrl.sv
// Directed bench: 2x2 array with a behavioural PE array and operand buffers around the sequencer.
module tb_systolic_mm_ctrl;
  localparam int DW   = 8;
  localparam int DIM  = 2;
  localparam int MAXK = 16;

  logic clk = 1'b0;
  logic rst_i, start_i, mode_i;
  logic [4:0] k_len_i;
  logic busy_o, done_o, res_valid_o, ovf_o, pe_start_o, pe_mode_o;
  logic [DIM-1:0][DW-1:0] a_feed_o, b_feed_o;
  logic [DIM*DIM-1:0] pe_ovf;

  systolic_mm_ctrl_if #(.DATA_WIDTH(DW), .DIM(DIM), .ADDR_W(4)) bif ();

  systolic_mm_ctrl #(.DATA_WIDTH(DW), .DIM(DIM), .MAX_K(MAXK), .K_W(5), .ADDR_W(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .k_len_i     (k_len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .res_valid_o (res_valid_o),
    .ovf_o       (ovf_o),
    .obuf        (bif),
    .a_feed_o    (a_feed_o),
    .b_feed_o    (b_feed_o),
    .pe_start_o  (pe_start_o),
    .pe_mode_o   (pe_mode_o),
    .pe_ovf_i    (pe_ovf)
  );

  always #5 clk = ~clk;

  // operand buffers, 1-cycle latency; output holds last word when not read
  logic [DIM-1:0][DW-1:0] amem [MAXK];
  logic [DIM-1:0][DW-1:0] bmem [MAXK];
  always @(posedge clk) begin
    if (bif.a_rd_en_o) bif.a_rdata_i <= amem[bif.a_addr_o];
    if (bif.b_rd_en_o) bif.b_rdata_i <= bmem[bif.b_addr_o];
  end

  // read log, sampled mid-cycle
  int rd_q[$];
  int b_rd_n = 0;
  always @(negedge clk) begin
    if (bif.a_rd_en_o) rd_q.push_back(int'(bif.a_addr_o));
    if (bif.b_rd_en_o && bif.b_addr_o == bif.a_addr_o) b_rd_n <= b_rd_n + 1;
  end

  // behavioural 2x2 PE array: A flows right, B flows down, 16-bit wrapping acc, sticky overflow
  logic signed [DW-1:0] ain [DIM][DIM], bin [DIM][DIM], ar [DIM][DIM], br [DIM][DIM];
  logic signed [15:0]   acc [DIM][DIM], prod [DIM][DIM];
  logic [16:0]          sum [DIM][DIM];
  logic                 ovm [DIM][DIM];

  always_comb begin
    pe_ovf = '0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        if (j == 0) ain[i][j] = a_feed_o[i];
        else        ain[i][j] = ar[i][j-1];
        if (i == 0) bin[i][j] = b_feed_o[j];
        else        bin[i][j] = br[i-1][j];
        prod[i][j] = ain[i][j] * bin[i][j];
        sum[i][j]  = {acc[i][j][15], acc[i][j]} + {prod[i][j][15], prod[i][j]};
        pe_ovf[i*DIM+j] = ovm[i][j];
      end
  end

  always @(posedge clk) begin
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        if (!pe_start_o) begin
          acc[i][j] <= '0; ar[i][j] <= '0; br[i][j] <= '0; ovm[i][j] <= 1'b0;
        end else begin
          acc[i][j] <= sum[i][j][15:0];
          ovm[i][j] <= ovm[i][j] | (sum[i][j][16] ^ sum[i][j][15]);
          ar[i][j]  <= ain[i][j];
          br[i][j]  <= bin[i][j];
        end
      end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_c(input string tag, input int c00, input int c01, input int c10, input int c11);
    chk({tag, "_c00"}, int'(acc[0][0]), c00);
    chk({tag, "_c01"}, int'(acc[0][1]), c01);
    chk({tag, "_c10"}, int'(acc[1][0]), c10);
    chk({tag, "_c11"}, int'(acc[1][1]), c11);
  endtask

  // entry k: A column k (lane i = row i), B row k (lane j = column j)
  task automatic ld(input int k, input int a0, input int a1, input int b0, input int b1);
    amem[k][0] = 8'(a0); amem[k][1] = 8'(a1);
    bmem[k][0] = 8'(b0); bmem[k][1] = 8'(b1);
  endtask

  // A=[[1,2],[3,4]], B=[[5,6],[7,8]]
  task automatic ld_t1();
    ld(0, 1, 3, 5, 6);
    ld(1, 2, 4, 7, 8);
  endtask

  // cycle n = the cycle after the n-th edge following the start sample edge
  task automatic run_job(input logic md, input int k, input int pulse_at,
                         output int dcyc, output int bsy, output int ps1, output int rv1,
                         output int ps2, output int brd0);
    int cyc;
    bsy = 0; dcyc = -1; ps2 = -1;
    @(negedge clk);
    rd_q.delete();
    brd0 = b_rd_n;
    mode_i = md; k_len_i = 5'(k); start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    ps1 = int'(pe_start_o);
    rv1 = int'(res_valid_o);
    for (int g = 0; g < 200; g++) begin
      if (cyc == 2) ps2 = int'(pe_start_o);
      if (busy_o) bsy++;
      if (done_o) begin
        dcyc = cyc;
        break;
      end
      start_i = (cyc == pulse_at);
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
  endtask

  function automatic int rdq_at(input int n);
    return (rd_q.size() > n) ? rd_q[n] : -1;
  endfunction

  initial begin
    int d, bz, p1, rv1, p2, b0, nd;
    rst_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; k_len_i = '0;
    for (int k = 0; k < MAXK; k++) ld(k, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_rvalid", int'(res_valid_o), 0);
    chk("rst_ovf", int'(ovf_o), 0);
    chk("rst_pe_start", int'(pe_start_o), 0);
    chk("rst_pe_mode", int'(pe_mode_o), 0);
    chk("rst_rd_en", int'(bif.a_rd_en_o), 0);
    chk("rst_feed", int'(a_feed_o) + int'(b_feed_o), 0);

    // basic 2x2x2 product, started from IDLE
    ld_t1();
    run_job(1'b0, 2, 0, d, bz, p1, rv1, p2, b0);
    chk("t1_done_cyc", d, 8);
    chk("t1_clear_pe_start", p1, 0);
    @(negedge clk);
    chk("t1_rvalid", int'(res_valid_o), 1);
    chk("t1_hold_pe_start", int'(pe_start_o), 1);
    chk("t1_hold_feed", int'(a_feed_o) + int'(b_feed_o), 0);
    chk("t1_ovf", int'(ovf_o), 0);
    chk_c("t1", 19, 22, 43, 50);

    // K=3 from HOLD, bias mode latched; busy spans CLEAR + K+2*DIM COMPUTE + DONE
    ld(0, 1, 4, 1, 2);
    ld(1, 2, 5, 3, 4);
    ld(2, 3, 6, 5, 6);
    run_job(1'b1, 3, 0, d, bz, p1, rv1, p2, b0);
    chk("t2_done_cyc", d, 9);
    chk("t2_busy_cycles", bz, 9);
    chk("t2_hold_start_pe_start", p1, 0);
    chk("t2_hold_start_rvalid", rv1, 0);
    chk("t2_pe_start_back", p2, 1);
    chk("t2_reads", rd_q.size(), 3);
    chk("t2_addr0", rdq_at(0), 0);
    chk("t2_addr1", rdq_at(1), 1);
    chk("t2_addr2", rdq_at(2), 2);
    chk("t2_b_reads", b_rd_n - b0, 3);
    @(negedge clk);
    chk("t2_pe_mode", int'(pe_mode_o), 1);
    chk_c("t2", 22, 28, 49, 64);

    // start pulsed mid-COMPUTE is dropped
    ld_t1();
    run_job(1'b0, 2, 4, d, bz, p1, rv1, p2, b0);
    chk("t3_done_cyc", d, 8);
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done_o) nd++;
    end
    chk("t3_extra_done", nd, 0);
    chk("t3_rvalid", int'(res_valid_o), 1);
    chk("t3_pe_mode", int'(pe_mode_o), 0);
    chk_c("t3", 19, 22, 43, 50);

    // saturating operands: every PE overflows, flag held through HOLD
    for (int k = 0; k < 4; k++) ld(k, 127, 127, 127, 127);
    run_job(1'b0, 4, 0, d, bz, p1, rv1, p2, b0);
    chk("t4_done_cyc", d, 10);
    @(negedge clk);
    chk("t4_ovf", int'(ovf_o), 1);
    repeat (3) @(negedge clk);
    chk("t4_ovf_held", int'(ovf_o), 1);

    // clean job clears the flag at its DONE
    ld_t1();
    run_job(1'b0, 2, 0, d, bz, p1, rv1, p2, b0);
    @(negedge clk);
    chk("t4b_ovf", int'(ovf_o), 0);
    chk_c("t4b", 19, 22, 43, 50);

    // overflow again, then reset in the middle of the next job at cnt=2
    for (int k = 0; k < 4; k++) ld(k, 127, 127, 127, 127);
    run_job(1'b0, 4, 0, d, bz, p1, rv1, p2, b0);
    ld_t1();
    @(negedge clk);
    k_len_i = 5'd2; mode_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;                 // cycle 1 (CLEAR)
    repeat (3) @(negedge clk);      // cycle 4: COMPUTE, cnt=2
    chk("t6_busy_before", int'(busy_o), 1);
    chk("t6_ovf_kept", int'(ovf_o), 1);
    rst_i = 1'b1;
    @(negedge clk);
    chk("t6_busy", int'(busy_o), 0);
    chk("t6_done", int'(done_o), 0);
    chk("t6_pe_start", int'(pe_start_o), 0);
    chk("t6_pe_mode", int'(pe_mode_o), 0);
    chk("t6_rd_en", int'(bif.a_rd_en_o), 0);
    chk("t6_ovf", int'(ovf_o), 0);
    chk("t6_feed", int'(a_feed_o) + int'(b_feed_o), 0);
    rst_i = 1'b0;
    nd = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done_o) nd++;
    end
    chk("t6_no_done", nd, 0);
    run_job(1'b0, 2, 0, d, bz, p1, rv1, p2, b0);
    chk("t6_fresh_done_cyc", d, 8);
    @(negedge clk);
    chk_c("t6_fresh", 19, 22, 43, 50);

    // K=0: straight through CLEAR/DONE, no reads, zero results
    run_job(1'b0, 0, 0, d, bz, p1, rv1, p2, b0);
    chk("t5_k0_done_cyc", d, 2);
    chk("t5_k0_reads", rd_q.size(), 0);
    @(negedge clk);
    chk("t5_k0_rvalid", int'(res_valid_o), 1);
    chk("t5_k0_ovf", int'(ovf_o), 0);
    chk_c("t5_k0", 0, 0, 0, 0);

    // K=MAX_K+3 saturates to MAX_K
    for (int k = 0; k < MAXK; k++) ld(k, 1, 1, 1, 1);
    run_job(1'b0, MAXK + 3, 0, d, bz, p1, rv1, p2, b0);
    chk("t5_sat_done_cyc", d, MAXK + 2 * DIM + 2);
    chk("t5_sat_reads", rd_q.size(), MAXK);
    chk("t5_sat_last_addr", rdq_at(MAXK - 1), MAXK - 1);
    @(negedge clk);
    chk_c("t5_sat", MAXK, MAXK, MAXK, MAXK);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
